// File: rtl/led_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_round_ctrl
// Brief    : Round sequencer for the 24-LED reaction-game sweep timer. Arms
//            the sweep timer, judges a press (or timeout) against a target
//            LED window, keeps score and repeats for ROUNDS rounds.
// Options  : ROUND_CTRL_STREAK_EN - every third consecutive hit scores +2.
// Revision : 1.0 - initial release
// ============================================================================
module led_round_ctrl #(
  parameter int ROUNDS      = 5,
  parameter int TGT_LO      = 16,
  parameter int TGT_HI      = 19,
  parameter int SHOW_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst,        // asynchronous, active-low
  input  logic        start,
  input  logic        btn,
  input  logic [23:0] led_in,
  input  logic        time_end,
  output logic        tmr_st,
  output logic [7:0]  score,
  output logic [7:0]  round,
  output logic        hit,
  output logic        miss,
  output logic [23:0] last_led,
  output logic        busy,
  output logic        done
);

  localparam int              c_CW        = $clog2(SHOW_CYCLES + 1);
  localparam logic [c_CW-1:0] c_SHOW_LAST = c_CW'(SHOW_CYCLES - 1);
  localparam logic [7:0]      c_ROUNDS    = 8'(ROUNDS);
  // Bits TGT_LO..TGT_HI set: the LEDs that count as a hit.
  localparam logic [23:0]     c_TGT_MASK  = (24'hFFFFFF >> (23 - TGT_HI)) &
                                            (24'hFFFFFF << TGT_LO);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RUN  = 3'd2,
    S_SHOW = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          r_state;
  logic [c_CW-1:0] r_show_cnt;

  logic       w_start_go;
  logic       w_judge;
  logic       w_judge_hit;
  logic       w_in_window;
  logic       w_bonus;
  logic [8:0] w_sum;
  logic [7:0] w_score_next;

  // A press counts only when every lit LED lies inside the target window.
  assign w_in_window = ((led_in & c_TGT_MASK) != 24'd0) &&
                       ((led_in & ~c_TGT_MASK) == 24'd0);

  assign w_start_go  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_judge     = (r_state == S_RUN) && (time_end || btn);
  // Timeout has priority over a press in the same cycle.
  assign w_judge_hit = (r_state == S_RUN) && !time_end && btn && w_in_window;

`ifdef ROUND_CTRL_STREAK_EN
  logic [1:0] r_streak;

  assign w_bonus = (r_streak == 2'd2);

  // Consecutive-hit counter; the third hit in a row takes the bonus and restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_streak <= 2'd0;
    end else if (w_start_go) begin
      r_streak <= 2'd0;
    end else if (w_judge) begin
      if (!w_judge_hit || w_bonus) r_streak <= 2'd0;
      else                         r_streak <= r_streak + 2'd1;
    end
  end
`else
  assign w_bonus = 1'b0;
`endif

  // Saturating score increment.
  assign w_sum        = {1'b0, score} + (w_bonus ? 9'd2 : 9'd1);
  assign w_score_next = w_sum[8] ? 8'hFF : w_sum[7:0];

  // Round sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_show_cnt <= '0;
      tmr_st     <= 1'b0;
      score      <= 8'd0;
      round      <= 8'd0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      last_led   <= 24'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          tmr_st <= 1'b0;
          if (start) begin
            score    <= 8'd0;
            round    <= 8'd0;
            last_led <= 24'd0;
            busy     <= 1'b1;
            done     <= 1'b0;
            r_state  <= S_ARM;
          end
        end
        S_ARM: begin
          tmr_st  <= 1'b1;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_judge) begin
            tmr_st     <= 1'b0;
            round      <= round + 8'd1;
            r_show_cnt <= c_SHOW_LAST;
            r_state    <= S_SHOW;
            if (time_end) begin
              miss     <= 1'b1;
              last_led <= 24'd0;
            end else begin
              last_led <= led_in;
              if (w_judge_hit) begin
                hit   <= 1'b1;
                score <= w_score_next;
              end else begin
                miss <= 1'b1;
              end
            end
          end
        end
        S_SHOW: begin
          if (r_show_cnt == '0) begin
            if (round == c_ROUNDS) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_ARM;
            end
          end else begin
            r_show_cnt <= r_show_cnt - 1'b1;
          end
        end
        default: begin
          tmr_st  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_round_ctrl
// Brief    : Self-checking bench for led_round_ctrl (randomized presses,
//            behavioural scoring model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_round_ctrl;

  localparam int ROUNDS = 4;
  localparam int SHOW   = 3;
  localparam int LO     = 16;
  localparam int HI     = 19;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, btn, time_end;
  logic [23:0] led_in;
  logic        tmr_st, hit, miss, busy, done;
  logic [7:0]  score, round;
  logic [23:0] last_led;

  int n_cmp = 0;
  int n_err = 0;

  // Game model
  int          m_score, m_round, m_run;
  logic [23:0] m_last;

  led_round_ctrl #(
    .ROUNDS(ROUNDS), .TGT_LO(LO), .TGT_HI(HI), .SHOW_CYCLES(SHOW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .btn(btn), .led_in(led_in),
    .time_end(time_end), .tmr_st(tmr_st), .score(score), .round(round),
    .hit(hit), .miss(miss), .last_led(last_led), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_target(input logic [23:0] v);
    if ($countones(v) != 1) return 1'b0;
    for (int i = 0; i < 24; i++)
      if (v[i]) return (i >= LO) && (i <= HI);
    return 1'b0;
  endfunction

  function automatic logic [23:0] one_hot(input int idx);
    logic [23:0] one;
    one = 24'h1;
    return one << idx;
  endfunction

  // Points for a hit: every third consecutive hit is worth 2 when streaks are on.
  function automatic int award();
    m_run++;
`ifdef ROUND_CTRL_STREAK_EN
    if (m_run % 3 == 0) return 2;
`endif
    return 1;
  endfunction

  task automatic model_start();
    m_score = 0; m_round = 0; m_run = 0; m_last = 24'd0;
  endtask

  // Entered right after the cycle in which the DUT is in ARM.
  task automatic play_round(input bit force_hit);
    int n, kind;
    cyc();
    chk("run_tmr_st", tmr_st, 1);
    n = $urandom_range(0, 3);
    repeat (n) begin
      led_in = one_hot($urandom_range(0, 23));
      start  = 1'($urandom_range(0, 1));
      cyc();
      chk("wait_tmr_st", tmr_st, 1);
      chk("wait_pulse", {hit, miss}, 0);
      chk("wait_round", round, m_round);
    end
    start = 1'b0;
    kind  = force_hit ? 0 : $urandom_range(0, 3);
    case (kind)
      0:       begin btn = 1; time_end = 0; led_in = one_hot($urandom_range(LO, HI)); end
      1:       begin btn = 1; time_end = 0; led_in = one_hot($urandom_range(0, 23)); end
      2:       begin btn = 0; time_end = 1; led_in = one_hot($urandom_range(0, 23)); end
      default: begin btn = 1; time_end = 1; led_in = one_hot($urandom_range(LO, HI)); end
    endcase
    begin : judge_model
      bit exp_hit;
      exp_hit = !time_end && is_target(led_in);
      if (time_end) begin m_last = 24'd0; m_run = 0; end
      else          m_last = led_in;
      if (exp_hit) begin
        m_score = m_score + award();
        if (m_score > 255) m_score = 255;
      end else m_run = 0;
      m_round++;
      cyc();
      btn = 0; time_end = 0;
      chk("judge_hit", hit, exp_hit);
      chk("judge_miss", miss, !exp_hit);
    end
    chk("judge_score", score, m_score);
    chk("judge_round", round, m_round);
    chk("judge_last_led", last_led, m_last);
    chk("show_tmr_st", tmr_st, 0);
    repeat (SHOW - 1) begin
      btn    = 1'($urandom_range(0, 1));
      led_in = one_hot($urandom_range(LO, HI));
      cyc();
      chk("show_pulse", {hit, miss}, 0);
      chk("show_state", {busy, tmr_st, done}, 3'b100);
      chk("show_score", score, m_score);
    end
    btn = 0;
    cyc();
    if (m_round == ROUNDS) chk("end_done", {busy, tmr_st, done}, 3'b001);
    else                   chk("end_arm", {busy, tmr_st, done}, 3'b100);
  endtask

  task automatic begin_game();
    start = 1;
    cyc();
    start = 0;
    model_start();
    chk("arm_state", {busy, tmr_st, done}, 3'b100);
    chk("arm_clear", {score, round, last_led}, 40'd0);
  endtask

  initial begin
    rst = 0; start = 0; btn = 0; time_end = 0; led_in = 24'd0;
    cyc(); cyc();
    chk("reset_outs", {tmr_st, score, round, hit, miss, last_led, busy, done}, 0);
    rst = 1;
    cyc();

    // Game 1: all hits, score sequence checked each round
    begin_game();
    for (int r = 0; r < ROUNDS; r++) play_round(1'b1);
`ifdef ROUND_CTRL_STREAK_EN
    chk("allhit_score", score, 5);
`else
    chk("allhit_score", score, 4);
`endif
    // Press in DONE is ignored
    btn = 1; led_in = 24'h010000;
    cyc();
    btn = 0;
    chk("done_btn", {done, busy, tmr_st, hit, miss}, 5'b10000);
    chk("done_btn_score", score, m_score);

    // Random games, each restarted from DONE
    for (int g = 0; g < 6; g++) begin
      begin_game();
      for (int r = 0; r < ROUNDS; r++) play_round(1'b0);
    end

    // Reset in RUN after a hit discards the game
    begin_game();
    play_round(1'b1);
    cyc();
    chk("pre_reset_run", {tmr_st, score}, {1'b1, 8'd1});
    #2;
    rst = 0;
    #1;
    chk("midreset_outs", {tmr_st, score, round, hit, miss, last_led, busy, done}, 0);
    cyc();
    rst = 1;
    btn = 1;
    cyc();
    btn = 0;
    chk("idle_btn", {busy, done, tmr_st, score}, 0);
    cyc();
    chk("idle_hold", {busy, done}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_round_ctrl.md
# led_round_ctrl

Round sequencer for the 24-LED sweep timer in the reaction game. It arms the sweep timer and waits for a player press or sweep timeout. It judges each press against a target LED window, keeps score, and repeats for a fixed number of rounds. It sits between the debounced button input and the sweep timer (drives the timer's active-low start/hold input, reads its LED vector and end flag) and feeds the score display.

## Interface
Parameters:
- ROUNDS, 5, rounds per game; legal 1..255
- TGT_LO, 16, lowest LED index counted as a hit
- TGT_HI, 19, highest LED index counted as a hit; TGT_LO <= TGT_HI <= 23
- SHOW_CYCLES, 50000000, cycles the result is held between rounds; >= 1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse, begins a game
- btn  in  1  one-cycle debounced press pulse
- led_in  in  24  sweep timer LED vector
- time_end  in  1  sweep timer end flag (level)
- tmr_st  out  1  to sweep timer start/hold input; 0 holds timer in reset, 1 lets it run
- score  out  8  accumulated points
- round  out  8  rounds completed
- hit  out  1  one-cycle pulse on a judged hit
- miss  out  1  one-cycle pulse on a judged miss or timeout
- last_led  out  24  led_in captured at the judging press, 0 on timeout
- busy  out  1  high in ARM/RUN/SHOW
- done  out  1  high in DONE

## Operation
- States: IDLE, ARM, RUN, SHOW, DONE.
- IDLE: tmr_st=0. start=1 → clear score, round, last_led → ARM.
- ARM: one cycle. tmr_st=0, so the timer returns to LED 0 lit. → RUN.
- RUN: tmr_st=1.
  - time_end=1 → miss, last_led=0.
  - Else btn=1 → judge.
  - Either case → SHOW, round+1.
- Judge: hit iff led_in is nonzero and the set bit index i satisfies TGT_LO <= i <= TGT_HI. Hit adds 1 to score; anything else is a miss.
- SHOW: tmr_st=0. Hold SHOW_CYCLES cycles. Then go to DONE if round==ROUNDS, else ARM.
- DONE: tmr_st=0, done=1. start=1 → clear score, round, last_led → ARM.
- Ignored inputs:
  - start outside IDLE/DONE.
  - btn outside RUN.
- Arithmetic: score and round are 8-bit, unsigned. round never exceeds ROUNDS. score saturates at 255 (reachable only with the streak bonus).

## Timing
- Reset (async, any state) → IDLE. Outputs: tmr_st=0, score=0, round=0, hit=0, miss=0, last_led=0, busy=0, done=0. Reset mid-round discards the round.
- start at cycle t → ARM at t+1 → RUN at t+2, with tmr_st=1 registered at t+2.
- Judging event (btn or time_end) at cycle t in RUN:
  - State, hit/miss, score, round and last_led all update at t+1 (SHOW entered).
  - hit/miss are high for cycle t+1 only.
- btn and time_end in the same cycle: timeout wins → miss.
- SHOW occupies exactly SHOW_CYCLES cycles. The first cycle after them is ARM or DONE.
- All outputs are registered.

## Configuration
- ROUND_CTRL_STREAK_EN defined:
  - Adds an internal 2-bit streak counter, cleared by reset, start, and any miss.
  - On each hit the streak counter increments. On the third consecutive hit, score gains +2 instead of +1 and the streak counter clears.
- Not defined: no streak logic; every hit adds exactly 1.

## Test plan
- Reset while in RUN with score=2 → next cycle IDLE, tmr_st=0, score=0, round=0, busy=0.
- ROUNDS=1, SHOW_CYCLES=4: start, then btn with led_in=24'h010000 (bit 16) → hit pulse 1 cycle, score=1, round=1, last_led=24'h010000. 4 cycles later → done=1.
- RUN, btn with led_in=24'h000800 (bit 11) → miss pulse, score unchanged. Then led_in=24'h100000 (bit 20) → miss.
- RUN, btn and time_end asserted same cycle with led_in=24'h020000 → miss, last_led=0, score unchanged.
- ROUNDS=3, all hits → score=3, done=1, tmr_st stays 0. btn in DONE → no change. start → score=0, ARM next cycle.
- With ROUND_CTRL_STREAK_EN: ROUNDS=4, four hits → scores 1,2,4,5. Without the macro → 1,2,3,4.
